uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver for the UART link; the receiving-end counterpart of the team's UART transmitter.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
- Samples each bit at its centre, reassembles the byte, checks parity and stop bit, then presents the byte with a one-cycle valid strobe to the downstream consumer (register file / FIFO).

Parameters:
- CHECK_MODE, 1: parity mode. 1 = odd (data bits plus parity bit hold an odd number of ones), 0 = even.
- BAUD_NUM, 50_000_000/115200 (434): clk cycles per bit.
- HALF, BAUD_NUM/2 (217, integer divide): mid-bit offset. Localparam, not overridable.

Ports:
- clk  in  1  50 MHz system clock.
- rstn  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, asynchronous to clk, idles high.
- rx_data  out  8  received byte.
- rx_data_valid  out  1  one-cycle strobe; rx_data and error flags are new.
- rx_parity_err  out  1  parity mismatch on the frame just strobed.
- rx_frame_err  out  1  stop bit sampled as 0 on the frame just strobed.
- rx_busy  out  1  high in every state except IDLE.

Behaviour:
- Input sync: 2-flop synchroniser on rx, both flops reset to 1. A third registered copy feeds falling-edge detection. All FSM logic uses the synchronised signal rx_s only.
- Counters:
  - baud_cnt, 9 bits. Held at 0 in IDLE. Counts 0..BAUD_NUM-1 otherwise and wraps to 0 at BAUD_NUM-1 (baud_end).
  - bit_cnt, 3 bits. Increments on baud_end in DATA only; forced to 0 in all other states.
  - Sample strobe: baud_cnt == HALF-1.
- FSM states: IDLE, START, DATA, CHECK, STOP.
  - IDLE -> START on a falling edge of rx_s. A line held low out of reset does not start a frame until a high-to-low edge is seen.
  - START: at the sample strobe, if rx_s == 1 (glitch / false start), go to IDLE. Otherwise stay until baud_end, then go to DATA.
  - DATA: at the sample strobe, shift_r[bit_cnt] <= sample. Go to CHECK on baud_end with bit_cnt == 7.
  - CHECK: at the sample strobe, capture par_r. Go to STOP on baud_end.
  - STOP: at the sample strobe, return to IDLE. The rest of the stop bit is not waited out, so a start edge immediately following the stop bit is caught.
- Output update, registered on the cycle the STOP sample strobe is taken:
  - rx_data <= shift_r.
  - rx_parity_err <= ((^shift_r) ^ par_r) != CHECK_MODE.
  - rx_frame_err <= ~sample.
  - rx_data_valid = 1 for exactly that one cycle.
  - A frame is always strobed even when it carries errors; the flags qualify it.
- rx_data and both error flags hold their values until the next strobe.
- Latency: rx_data_valid rises HALF+2..HALF+3 clk after the stop-bit leading edge appears on the rx pin.
- Reset (including mid-frame): state = IDLE, counters = 0, rx_data = 0, rx_data_valid = 0, both error flags = 0, rx_busy = 0, sync flops = 1. A partially received frame is discarded with no strobe.
- Simultaneous events: a falling edge arriving on the same cycle STOP exits to IDLE is not lost. IDLE registers the edge from the delayed copy on the next cycle.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rx_s taken at baud_cnt == HALF-2, HALF-1 and HALF.
  - Decisions and transitions still occur at HALF.
  - The STOP strobe and the output update move to baud_cnt == HALF, so valid latency grows by 1 clk.
- Undefined: single sample at HALF-1, as above.

Test Plan:
- Odd mode, send 0xA5 with parity bit 1 and stop 1 at BAUD_NUM=434 -> one strobe, rx_data=0xA5, parity_err=0, frame_err=0, rx_busy low afterwards.
- Even mode (CHECK_MODE=0), send 0x3C with parity bit 1 (wrong) -> rx_data=0x3C, rx_parity_err=1, frame_err=0.
- Send 0x00 with stop bit driven 0 -> strobe with rx_frame_err=1, rx_data=0x00.
- Low pulse of 100 clk on idle line -> no strobe, FSM back in IDLE by cnt HALF-1, rx_busy pulse < HALF+3 clk.
- Back-to-back frames 0x55 then 0xAA, stop bit exactly 434 clk -> two strobes 11*434 clk apart (±1), data correct.
- Assert rstn low mid-DATA of a frame, release, then send 0x81 -> no strobe for the aborted frame; 0x81 received cleanly. With UART_RX_MAJORITY_EN, a 1-clk glitch at the HALF-1 point of bit 3 does not corrupt the data.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8-bit + parity + stop UART receiver; UART_RX_MAJORITY_EN selects 2-of-3 mid-bit voting.
// Latency: strobe HALF+2..3 clk after stop-bit edge (+1 when voting); no backpressure, consumer takes the strobe.
module uart_rx #(
  parameter int CHECK_MODE = 1,
  parameter int BAUD_NUM   = 50_000_000 / 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_busy
);
  localparam int HALF = BAUD_NUM / 2;
  localparam logic [8:0] BAUD_LAST = 9'(BAUD_NUM - 1);
  localparam logic       ODD_MODE  = 1'(CHECK_MODE);

  typedef enum logic [2:0] {IDLE, START, DATA, CHECK, STOP} state_t;

  state_t     state, state_n;
  logic       rx_q1, rx_s, rx_d;
  logic [8:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_r;
  logic       par_r;
  logic       fall_pend;
  logic       fall, baud_end, smp_tick, sample;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
      rx_d  <= rx_s;
    end
  end

  assign fall     = rx_d & ~rx_s;
  assign baud_end = (baud_cnt == BAUD_LAST);

`ifdef UART_RX_MAJORITY_EN
  logic smp_a, smp_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else begin
      if (baud_cnt == 9'(HALF - 2)) smp_a <= rx_s;
      if (baud_cnt == 9'(HALF - 1)) smp_b <= rx_s;
    end
  end

  assign smp_tick = (baud_cnt == 9'(HALF));
  assign sample   = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
`else
  assign smp_tick = (baud_cnt == 9'(HALF - 1));
  assign sample   = rx_s;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fall || fall_pend) state_n = START;
      START: begin
        if (smp_tick && sample) state_n = IDLE;
        else if (baud_end)      state_n = DATA;
      end
      DATA:    if (baud_end && bit_cnt == 3'd7) state_n = CHECK;
      CHECK:   if (baud_end) state_n = STOP;
      STOP:    if (smp_tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A start edge landing on the cycle STOP exits would be invisible to IDLE, so hold it one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fall_pend <= 1'b0;
    else       fall_pend <= (state == STOP) && smp_tick && fall;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == IDLE || baud_end) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + 9'd1;
      if (state != DATA)  bit_cnt <= '0;
      else if (baud_end)  bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_r       <= '0;
      par_r         <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_data_valid <= 1'b0;
    end else begin
      rx_data_valid <= 1'b0;
      if (smp_tick) begin
        if (state == DATA)  shift_r[bit_cnt] <= sample;
        if (state == CHECK) par_r <= sample;
        if (state == STOP) begin
          rx_data       <= shift_r;
          rx_parity_err <= ((^shift_r) ^ par_r) != ODD_MODE;
          rx_frame_err  <= ~sample;
          rx_data_valid <= 1'b1;
        end
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: odd- and even-parity instances share one rx line, checked against a frame-level model.
module tb_uart_rx;
  localparam int BAUD  = 434;
  localparam int HALF  = BAUD / 2;
  localparam int FRAME = 11 * BAUD;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       pe_odd;
    logic       pe_even;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] d_o, d_e;
  logic       v_o, v_e, pe_o, pe_e, fe_o, fe_e, busy_o, busy_e;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   stop_cyc = 0;
  int   strb_cyc = 0;
  int   prev_strb_cyc = 0;
  int   n_strb = 0;
  int   busy_len = 0;
  int   last_busy_len = 0;
  exp_t exp_q[$];

  uart_rx #(.CHECK_MODE(1), .BAUD_NUM(BAUD)) dut_odd (
    .clk(clk), .rstn(rstn), .rx(rx), .rx_data(d_o), .rx_data_valid(v_o),
    .rx_parity_err(pe_o), .rx_frame_err(fe_o), .rx_busy(busy_o));

  uart_rx #(.CHECK_MODE(0), .BAUD_NUM(BAUD)) dut_even (
    .clk(clk), .rstn(rstn), .rx(rx), .rx_data(d_e), .rx_data_valid(v_e),
    .rx_parity_err(pe_e), .rx_frame_err(fe_e), .rx_busy(busy_e));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (busy_o) busy_len++;
    else if (busy_len > 0) begin
      last_busy_len = busy_len;
      busy_len = 0;
    end
    if (v_o || v_e) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", 32'(v_o | v_e), 32'd0);
      end else begin
        exp_t e;
        int   lat;
        e = exp_q.pop_front();
        lat = cyc - stop_cyc;
        prev_strb_cyc = strb_cyc;
        strb_cyc = cyc;
        n_strb++;
        check("vld_odd", 32'(v_o), 32'd1);
        check("vld_even", 32'(v_e), 32'd1);
        check("data_odd", 32'(d_o), 32'(e.d));
        check("data_even", 32'(d_e), 32'(e.d));
        check("perr_odd", 32'(pe_o), 32'(e.pe_odd));
        check("perr_even", 32'(pe_e), 32'(e.pe_even));
        check("ferr_odd", 32'(fe_o), 32'(e.fe));
        check("ferr_even", 32'(fe_e), 32'(e.fe));
        check("latency_in_range",
              32'((lat >= HALF + 2 + MAJ) && (lat <= HALF + 3 + MAJ)), 32'd1);
      end
    end
  end

  // Drives one frame; abort_bit >= 0 pulls reset partway through that bit; glitch flips the line for
  // one clk at the centre of data bit 3.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int abort_bit, input bit glitch);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    if (abort_bit < 0) begin
      exp_t e;
      e.d       = d;
      e.pe_odd  = (($countones(d) + int'(par)) % 2) != 1;
      e.pe_even = (($countones(d) + int'(par)) % 2) != 0;
      e.fe      = ~stp;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rx = bits[i];
      if (i == 10) stop_cyc = cyc + 1;
      for (int j = 1; j < BAUD; j++) begin
        @(negedge clk);
        if (i == abort_bit && j == 100) begin
          rstn = 1'b0;
          repeat (3) @(negedge clk);
          check("rst_data", 32'(d_o), 32'd0);
          check("rst_flags", 32'({v_o, pe_o, fe_o}), 32'd0);
          check("rst_busy", 32'(busy_o), 32'd0);
          rx = 1'b1;
          rstn = 1'b1;
          return;
        end
        rx = (glitch && i == 4 && j == HALF) ? ~bits[i] : bits[i];
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (5) @(negedge clk);
    check("reset_data", 32'(d_o), 32'd0);
    check("reset_valid", 32'({v_o, v_e}), 32'd0);
    check("reset_errflags", 32'({pe_o, fe_o, pe_e, fe_e}), 32'd0);
    check("reset_busy", 32'({busy_o, busy_e}), 32'd0);
    rstn = 1'b1;
    idle(20);

    send_frame(8'hA5, 1'b1, 1'b1, -1, 1'b0);
    idle(HALF);
    check("busy_after_A5", 32'(busy_o), 32'd0);
    check("strobes_after_A5", 32'(n_strb), 32'd1);

    send_frame(8'h3C, 1'b1, 1'b1, -1, 1'b0);
    idle(50);
    send_frame(8'h00, 1'b1, 1'b0, -1, 1'b0);
    idle(50);

    // False start: 100-clk low pulse must not produce a strobe.
    rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(2 * BAUD);
    check("glitch_no_strobe", 32'(n_strb), 32'd3);
    check("glitch_busy_short", 32'((last_busy_len > 0) && (last_busy_len < HALF + 3)), 32'd1);
    check("glitch_idle", 32'(busy_o), 32'd0);

    send_frame(8'h55, 1'b1, 1'b1, -1, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b1, -1, 1'b0);
    idle(HALF + 20);
    check("b2b_count", 32'(n_strb), 32'd5);
    check("b2b_gap", 32'((strb_cyc - prev_strb_cyc >= FRAME - 1) &&
                         (strb_cyc - prev_strb_cyc <= FRAME + 1)), 32'd1);

    send_frame(8'hC3, 1'b0, 1'b1, 5, 1'b0);
    idle(50);
    send_frame(8'h81, 1'b1, 1'b1, -1, MAJ != 0);
    idle(HALF + 20);
    check("after_abort_count", 32'(n_strb), 32'd6);

    for (int k = 0; k < 6; k++) begin
      send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), -1, 1'b0);
      idle($urandom_range(0, 60));
    end
    idle(HALF + 20);
    check("all_frames_seen", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'({busy_o, busy_e}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
